// File: rtl/daq_pkg.sv
// Shared capture-path types: sequencer state encoding and timestamp width.
// Combinational only (no latency); no flow control.
// Backpressure: not applicable.
package daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_READOUT
    } cap_state_t;

    localparam int TS_W = 32;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en; rd_q holds while rd_en is low.
// Backpressure: none; the caller stalls by withholding rd_en.
module capture_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Pre/post-trigger ADC capture into a ring buffer, then oldest-first readout stream.
// Latency: first word one cycle after READOUT entry, then 1 word/cycle; optional CAPTURE_TIMESTAMP_EN adds trig_ts.
// Backpressure: rd_valid/rd_ready; rd_data/rd_valid hold while stalled.
module capture_sequencer
    import daq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc,
    input  logic              trig_condition,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W:0]   post_len,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]   trig_ts
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    cap_state_t state, next_state;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr, fill_cnt, pre_q;
    logic [ADDR_W:0]   post_q, post_cnt, rd_left;
    logic [ADDR_W:0]   post_nz, post_clamp, post_eff_d;
    logic [ADDR_W+1:0] len_sum;
    logic [DATA_W-1:0] ram_q;
    logic              wr_en, rd_en, trig_acc, fill_last, post_last;

    // Post length as it will be used: zero means one, and never overrun the ring.
    always_comb begin
        post_nz    = (post_len == '0) ? ONE : post_len;
        len_sum    = {1'b0, post_nz} + {2'b00, pre_len};
        post_clamp = (ADDR_W+1)'(DEPTH) - {1'b0, pre_len};
        post_eff_d = (len_sum > (ADDR_W+2)'(DEPTH)) ? post_clamp : post_nz;
    end

    assign fill_last = (pre_q == '0) || ({1'b0, fill_cnt} + ONE == {1'b0, pre_q});
    assign post_last = (post_cnt + ONE == post_q);
    assign trig_acc  = (state == ST_WAIT_TRIG) && trig_condition && !abort;
    assign rd_en     = (state == ST_READOUT) && !abort && (rd_left != '0)
                       && (!rd_valid || rd_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (arm) next_state = ST_PREFILL;
                ST_PREFILL:   if (fill_last) next_state = ST_WAIT_TRIG;
                ST_WAIT_TRIG: if (trig_condition) next_state = (post_q == ONE) ? ST_READOUT : ST_POST;
                ST_POST:      if (post_last) next_state = ST_READOUT;
                ST_READOUT:   if (rd_valid && rd_ready && rd_last) next_state = ST_IDLE;
                default:      next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        wr_en = (state == ST_PREFILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill_cnt  <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            post_cnt  <= '0;
            rd_left   <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            if (state == ST_IDLE && next_state == ST_PREFILL) begin
                pre_q    <= pre_len;
                post_q   <= post_eff_d;
                rd_left  <= {1'b0, pre_len} + post_eff_d;
                wr_ptr   <= '0;
                fill_cnt <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == ST_PREFILL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (state == ST_POST) begin
                post_cnt <= post_cnt + ONE;
            end
            // The trigger sample lands at wr_ptr, so the oldest pre sample sits pre_q behind it.
            if (trig_acc) begin
                rd_ptr   <= wr_ptr - pre_q;
                post_cnt <= ONE;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_left <= rd_left - ONE;
            end

            if (next_state == ST_IDLE) begin
                triggered <= 1'b0;
            end else if (trig_acc) begin
                triggered <= 1'b1;
            end

            if (next_state == ST_IDLE) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else if (rd_en) begin
                rd_valid <= 1'b1;
                rd_last  <= (rd_left == ONE);
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end

            done <= (state == ST_READOUT) && (next_state == ST_IDLE) && !abort;
        end
    end

    // The RAM read register doubles as the output stage: it only reloads on rd_en.
    assign rd_data = rd_valid ? ram_q : '0;

    capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (adc),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_q    (ram_q)
    );

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (trig_acc) begin
                trig_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed scoreboard bench for capture_sequencer on a 16-deep buffer.
module tb_capture_sequencer;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] adc = '0;
    logic          trig_condition = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] pre_len = '0;
    logic [AW:0]   post_len = '0;
    logic          busy, triggered, done, rd_valid, rd_last;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [daq_pkg::TS_W-1:0] trig_ts;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    capture_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .adc            (adc),
        .trig_condition (trig_condition),
        .arm            (arm),
        .abort          (abort),
        .pre_len        (pre_len),
        .post_len       (post_len),
        .busy           (busy),
        .triggered      (triggered),
        .done           (done),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_last        (rd_last),
        .rd_ready       (rd_ready)
`ifdef CAPTURE_TIMESTAMP_EN
        ,
        .trig_ts        (trig_ts)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the ADC ramp advances once per cycle and outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        adc = adc + 1'b1;
    endtask

    // Arm, optionally pulse an early trigger, trigger when the ramp reaches trig_val, and queue expectations.
    task automatic run_capture(input int pre, input int post, input int early_val, input int trig_val);
        int pn;
        int guard;
        pre_len  = AW'(pre);
        post_len = (AW+1)'(post);
        adc      = '0;
        arm      = 1'b1;
        tick();
        arm = 1'b0;
        check("busy_after_arm", {31'b0, busy}, 1);
        guard = 0;
        while (int'(adc) != trig_val && guard < 2000) begin
            if (int'(adc) == early_val) begin
                trig_condition = 1'b1;
                tick();
                trig_condition = 1'b0;
                check("early_trig_ignored", {31'b0, triggered}, 0);
            end else begin
                tick();
            end
            guard++;
        end
        check("trig_wait_bound", {31'b0, guard < 2000}, 1);
        trig_condition = 1'b1;
        tick();
        trig_condition = 1'b0;
        check("triggered_set", {31'b0, triggered}, 1);
        pn = (post == 0) ? 1 : post;
        if (pre + pn > DEPTH) pn = DEPTH - pre;
        for (int i = 0; i < pre + pn; i++) begin
            sb.push_back(DW'(trig_val - pre + i));
        end
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready high one cycle in three.
    task automatic drain(input int mode, input int max_words);
        int            n;
        int            cyc;
        logic          held_v;
        logic [DW-1:0] held_d;
        logic [DW-1:0] exp;
        n      = 0;
        cyc    = 0;
        held_v = 1'b0;
        held_d = '0;
        while (n < max_words && cyc < 500) begin
            rd_ready = (mode == 0) || (cyc % 3 == 0);
            if (held_v) begin
                check("stall_valid_held", {31'b0, rd_valid}, 1);
                check("stall_data_held", {16'b0, rd_data}, {16'b0, held_d});
            end
            if (mode == 0 && n > 0) begin
                check("no_bubble", {31'b0, rd_valid}, 1);
            end
            if (rd_valid && rd_ready) begin
                check("sb_nonempty", {31'b0, sb.size() != 0}, 1);
                exp = (sb.size() != 0) ? sb.pop_front() : '0;
                check("rd_data", {16'b0, rd_data}, {16'b0, exp});
                check("rd_last", {31'b0, rd_last}, {31'b0, sb.size() == 0});
                n++;
                held_v = 1'b0;
            end else begin
                held_v = rd_valid;
                held_d = rd_data;
            end
            tick();
            cyc++;
        end
        check("drain_bound", {31'b0, cyc < 500}, 1);
        rd_ready = 1'b0;
    endtask

    task automatic finish_checks();
        check("done_pulse", {31'b0, done}, 1);
        check("busy_idle", {31'b0, busy}, 0);
        check("triggered_cleared", {31'b0, triggered}, 0);
        check("sb_empty", sb.size(), 0);
        tick();
        check("done_one_cycle", {31'b0, done}, 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_triggered", {31'b0, triggered}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_rd_valid", {31'b0, rd_valid}, 0);
        check("rst_rd_last", {31'b0, rd_last}, 0);
        check("rst_rd_data", {16'b0, rd_data}, 0);
        reset = 1'b0;
        adc   = '0;

`ifdef CAPTURE_TIMESTAMP_EN
        // Arm lands on cycle 0 after reset, so the ramp value equals the cycle number.
        run_capture(0, 1, -1, 1000);
        check("trig_ts", trig_ts, 1000);
        drain(0, 1);
        finish_checks();
`endif

        // Nominal: 16..23, rd_last on 23.
        run_capture(4, 4, -1, 20);
        drain(0, 8);
        finish_checks();

        // Early trigger in PREFILL ignored; real trigger at 30 gives 22..33.
        run_capture(8, 4, 2, 30);
        drain(0, 12);
        finish_checks();

        // Clamp to 16 words, read contiguous across the ring wrap: 28..43.
        run_capture(12, 10, -1, 40);
        drain(0, 16);
        finish_checks();

        // post_len=0 behaves as 1; pre_len=0 starts at the trigger sample.
        run_capture(3, 0, -1, 25);
        drain(0, 4);
        finish_checks();
        run_capture(0, 3, -1, 10);
        drain(0, 3);
        finish_checks();

        // Backpressure with rd_ready one cycle in three.
        run_capture(5, 6, -1, 33);
        drain(1, 11);
        finish_checks();

        // Abort after three words.
        run_capture(4, 8, -1, 50);
        drain(0, 3);
        abort    = 1'b1;
        rd_ready = 1'b1;
        tick();
        abort    = 1'b0;
        rd_ready = 1'b0;
        check("abort_rd_valid", {31'b0, rd_valid}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_triggered", {31'b0, triggered}, 0);
        check("abort_no_done", {31'b0, done}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_done_quiet", {31'b0, done}, 0);
        end
        sb.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
